// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add sequencer.
// Holds default sizing, the FSM state encoding and a constant clog2 helper.
// No logic lives here.
package mp_add_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int NWORDS_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    FIN  = ST_FIN
  } state_t;

  // Ceiling log2, used to size the word counter; at least 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mp_add_seq_slice.sv
// Purpose: combinational WORD_W-bit ripple-carry adder built from full-adder cells.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the sequencer decides when the result is used.
module add_word_slice
  import mp_add_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  // Chain of full-adder cells, LSB first; the carry is a local so the chain stays acyclic.
  always_comb begin
    logic w_c;
    w_c = cin;
    s   = '0;
    for (int i = 0; i < WORD_W; i++) begin
      s[i] = x[i] ^ y[i] ^ w_c;
      w_c  = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/mp_add_seq.sv
// Purpose: NWORDS*WORD_W-bit add (optional subtract via MP_ADD_SEQ_SUB_EN) through one word slice.
// Latency: start at edge T, done in the cycle after edge T+NWORDS; one op per NWORDS+2 cycles.
// Backpressure: start is ignored (not queued) while busy; operands are captured on acceptance.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic                     sub,
`endif
  input  logic [NWORDS*WORD_W-1:0] a,
  input  logic [NWORDS*WORD_W-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [NWORDS*WORD_W-1:0] sum,
  output logic                     cout
);

  localparam int              KW     = clog2(NWORDS);
  localparam logic [KW-1:0]   K_LAST = KW'(NWORDS - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [NWORDS*WORD_W-1:0]   r_a;
  logic [NWORDS*WORD_W-1:0]   r_b;
  logic [NWORDS*WORD_W-1:0]   r_sum;
  logic                       r_carry;
  logic                       r_cout;
  logic [KW-1:0]              r_k;

  logic                       w_accept;
  logic                       w_last;
  logic                       w_invert;
  logic                       w_cin_init;
  logic [WORD_W-1:0]          w_x;
  logic [WORD_W-1:0]          w_y;
  logic [WORD_W-1:0]          w_s;
  logic                       w_co;

`ifdef MP_ADD_SEQ_SUB_EN
  logic                       r_sub;

  // Subtract mode flag is captured alongside the operands.
  always_ff @(posedge clk) begin
    if (rst)           r_sub <= 1'b0;
    else if (w_accept) r_sub <= sub;
  end

  assign w_invert   = r_sub;
  assign w_cin_init = sub;
`else
  assign w_invert   = 1'b0;
  assign w_cin_init = 1'b0;
`endif

  assign w_last = (r_k == K_LAST);
  assign w_x    = r_a[int'(r_k)*WORD_W +: WORD_W];
  assign w_y    = r_b[int'(r_k)*WORD_W +: WORD_W] ^ {WORD_W{w_invert}};
  assign sum    = r_sum;
  assign cout   = r_cout;

  add_word_slice #(.WORD_W(WORD_W)) u_slice (
    .x   (w_x),
    .y   (w_y),
    .cin (r_carry),
    .s   (w_s),
    .co  (w_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = FIN;
      end
      FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture and word-serial accumulation with the carry chained through r_carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= w_cin_init;
      r_cout  <= 1'b0;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_sum[int'(r_k)*WORD_W +: WORD_W] <= w_s;
      r_carry <= w_co;
      if (w_last) begin
        r_cout <= w_co;
        r_k    <= '0;
      end else begin
        r_k    <= r_k + KW'(1);
      end
    end
  end

endmodule
